// File: rtl/floo_route_comp_arb.sv
`default_nettype none
// ============================================================================
// Module   : floo_route_comp_arb
// Brief    : Round-robin shared route-computation stage with per-channel
//            registered result slots and a saturating decode-error counter.
// Revision : 1.0
// ============================================================================
module floo_route_comp_arb #(
    parameter int unsigned NUM_CHANNELS     = 2,
    parameter int unsigned ROUTE_ALGO       = 0,    // 0: IdTable, 1: XYRouting, 2: SourceRouting
    parameter bit          USE_ID_TABLE     = 1'b1,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned ID_WIDTH         = 8,
    parameter int unsigned XY_X_WIDTH       = 4,
    parameter int unsigned XY_Y_WIDTH       = 4,
    parameter int unsigned ROUTE_WIDTH      = 8,
    parameter int unsigned XY_ADDR_OFFSET_X = 0,
    parameter int unsigned XY_ADDR_OFFSET_Y = 0,
    parameter int unsigned ID_ADDR_OFFSET   = 0,
    parameter int unsigned NUM_ADDR_RULES   = 1,
    parameter int unsigned NUM_ROUTES       = 1,
    parameter int unsigned ERR_CNT_WIDTH    = 16
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic [NUM_CHANNELS-1:0]                               valid_i,
    output logic [NUM_CHANNELS-1:0]                               ready_o,
    input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]               addr_i,
    input  logic [NUM_CHANNELS-1:0][ID_WIDTH-1:0]                 id_i,
    // Each rule is packed as {idx, start_addr, end_addr}; the range is [start, end).
    input  logic [NUM_ADDR_RULES-1:0][ID_WIDTH+2*ADDR_WIDTH-1:0]  addr_map_i,
    input  logic [NUM_ROUTES-1:0][ROUTE_WIDTH-1:0]                route_table_i,
    output logic [NUM_CHANNELS-1:0]                               valid_o,
    input  logic [NUM_CHANNELS-1:0]                               ready_i,
    output logic [NUM_CHANNELS-1:0][ID_WIDTH-1:0]                 id_o,
    output logic [NUM_CHANNELS-1:0][ROUTE_WIDTH-1:0]              route_o,
    output logic [NUM_CHANNELS-1:0]                               err_o,
    output logic [ERR_CNT_WIDTH-1:0]                              err_cnt_o,
    input  logic                                                  clear_err_i
);

    localparam int unsigned c_ptr_w      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned c_algo_idtab = 0;
    localparam int unsigned c_algo_xy    = 1;
    localparam int unsigned c_algo_src   = 2;

    logic [NUM_CHANNELS-1:0]                  r_valid;
    logic [NUM_CHANNELS-1:0][ID_WIDTH-1:0]    r_id;
    logic [NUM_CHANNELS-1:0][ROUTE_WIDTH-1:0] r_route;
    logic [NUM_CHANNELS-1:0]                  r_err;
    logic [c_ptr_w-1:0]                       r_ptr;
    logic [ERR_CNT_WIDTH-1:0]                 r_err_cnt;

    logic [NUM_CHANNELS-1:0] w_eligible;
    logic [NUM_CHANNELS-1:0] w_ready;
    logic                    w_gnt_any;
    logic [c_ptr_w-1:0]      w_gnt_idx;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ID_WIDTH-1:0]     w_id_in;
    logic [ID_WIDTH-1:0]     w_dec_id;
    logic                    w_dec_err;
    logic [ROUTE_WIDTH-1:0]  w_route;
    logic                    w_route_err;
    logic                    w_err;
    logic [ERR_CNT_WIDTH-1:0] w_err_cnt_nxt;
    logic                    w_unused;

    assign w_unused   = ^{id_i, addr_i, addr_map_i, route_table_i};
    assign w_eligible = valid_i & (~r_valid | ready_i);

    // Two passes: first eligible at or above the pointer, otherwise wrap to the lowest.
    always_comb begin
        w_ready   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (!w_gnt_any && w_eligible[c] && (c >= 32'(r_ptr))) begin
                w_gnt_any  = 1'b1;
                w_gnt_idx  = c_ptr_w'(c);
                w_ready[c] = 1'b1;
            end
        end
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (!w_gnt_any && w_eligible[c]) begin
                w_gnt_any  = 1'b1;
                w_gnt_idx  = c_ptr_w'(c);
                w_ready[c] = 1'b1;
            end
        end
    end

    always_comb begin
        w_addr  = '0;
        w_id_in = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (w_ready[c]) begin
                w_addr  = addr_i[c];
                w_id_in = id_i[c];
            end
        end
    end

    if (USE_ID_TABLE) begin : g_dec_table
        logic w_hit;
        always_comb begin
            w_hit    = 1'b0;
            w_dec_id = '0;
            for (int unsigned r = 0; r < NUM_ADDR_RULES; r++) begin
                if (!w_hit &&
                    (w_addr >= addr_map_i[r][ADDR_WIDTH +: ADDR_WIDTH]) &&
                    (w_addr <  addr_map_i[r][0 +: ADDR_WIDTH])) begin
                    w_hit    = 1'b1;
                    w_dec_id = addr_map_i[r][2*ADDR_WIDTH +: ID_WIDTH];
                end
            end
            w_dec_err = !w_hit;
        end
    end else if (ROUTE_ALGO == c_algo_xy) begin : g_dec_xy
        // Destination ID is packed {y, x} with x in the low bits.
        assign w_dec_id  = ID_WIDTH'({w_addr[XY_ADDR_OFFSET_Y +: XY_Y_WIDTH],
                                      w_addr[XY_ADDR_OFFSET_X +: XY_X_WIDTH]});
        assign w_dec_err = 1'b0;
    end else if (ROUTE_ALGO == c_algo_idtab) begin : g_dec_addr
        assign w_dec_id  = w_addr[ID_ADDR_OFFSET +: ID_WIDTH];
        assign w_dec_err = 1'b0;
    end else begin : g_dec_srcid
        assign w_dec_id  = w_id_in;
        assign w_dec_err = 1'b0;
    end

    if (ROUTE_ALGO == c_algo_src) begin : g_route_src
        logic [ID_WIDTH-1:0] w_idx;
        assign w_idx = USE_ID_TABLE ? w_dec_id : w_id_in;
        always_comb begin
            w_route     = '0;
            w_route_err = (32'(w_idx) >= NUM_ROUTES);
            for (int unsigned r = 0; r < NUM_ROUTES; r++) begin
                if (32'(w_idx) == r) begin
                    w_route = route_table_i[r];
                end
            end
        end
    end else if ((ROUTE_ALGO == c_algo_idtab) || (ROUTE_ALGO == c_algo_xy)) begin : g_route_none
        assign w_route     = '0;
        assign w_route_err = 1'b0;
    end else begin : g_bad_algo
        $fatal(1, "floo_route_comp_arb: unsupported ROUTE_ALGO");
    end

    assign w_err = w_dec_err | w_route_err;

    // Clear takes effect first so that clear plus a simultaneous error yields 1.
    always_comb begin
        w_err_cnt_nxt = clear_err_i ? '0 : r_err_cnt;
        if (w_gnt_any && w_err && !(&w_err_cnt_nxt)) begin
            w_err_cnt_nxt = w_err_cnt_nxt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= '0;
            r_id      <= '0;
            r_route   <= '0;
            r_err     <= '0;
            r_ptr     <= '0;
            r_err_cnt <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                if (w_ready[c]) begin
                    r_valid[c] <= 1'b1;
                    r_id[c]    <= w_dec_id;
                    r_route[c] <= w_route;
                    r_err[c]   <= w_err;
                end else if (ready_i[c]) begin
                    r_valid[c] <= 1'b0;
                end
            end
            if (w_gnt_any) begin
                r_ptr <= (w_gnt_idx == c_ptr_w'(NUM_CHANNELS - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign ready_o   = w_ready;
    assign valid_o   = r_valid;
    assign id_o      = r_id;
    assign route_o   = r_route;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_floo_route_comp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_floo_route_comp_arb
// Brief    : Three configurations (rule table, source routing, XY) driven in
//            lockstep and compared against a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_floo_route_comp_arb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       in_valid [3];
    logic [1:0]       in_ready [3];
    logic [1:0][31:0] in_addr  [3];
    logic [1:0][7:0]  in_id    [3];
    logic             in_clear [3];

    logic [2:0][71:0] amap;
    logic [3:0][7:0]  rtab;

    logic [1:0] t_rdy, t_v, t_err;  logic [1:0][7:0] t_id, t_rt;  logic [2:0]  t_cnt;
    logic [1:0] s_rdy, s_v, s_err;  logic [1:0][7:0] s_id, s_rt;  logic [15:0] s_cnt;
    logic       x_rdy, x_v, x_err;  logic [7:0]      x_id, x_rt;  logic [15:0] x_cnt;

    floo_route_comp_arb #(
        .NUM_CHANNELS(2), .ROUTE_ALGO(0), .USE_ID_TABLE(1'b1), .ADDR_WIDTH(32),
        .ID_WIDTH(8), .ROUTE_WIDTH(8), .NUM_ADDR_RULES(3), .NUM_ROUTES(1), .ERR_CNT_WIDTH(3)
    ) u_tab (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(in_valid[0]), .ready_o(t_rdy),
        .addr_i(in_addr[0]), .id_i(in_id[0]), .addr_map_i(amap), .route_table_i(8'h00),
        .valid_o(t_v), .ready_i(in_ready[0]), .id_o(t_id), .route_o(t_rt), .err_o(t_err),
        .err_cnt_o(t_cnt), .clear_err_i(in_clear[0])
    );

    floo_route_comp_arb #(
        .NUM_CHANNELS(2), .ROUTE_ALGO(2), .USE_ID_TABLE(1'b0), .ADDR_WIDTH(32),
        .ID_WIDTH(8), .ROUTE_WIDTH(8), .NUM_ADDR_RULES(1), .NUM_ROUTES(4), .ERR_CNT_WIDTH(16)
    ) u_src (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(in_valid[1]), .ready_o(s_rdy),
        .addr_i(in_addr[1]), .id_i(in_id[1]), .addr_map_i(72'h0), .route_table_i(rtab),
        .valid_o(s_v), .ready_i(in_ready[1]), .id_o(s_id), .route_o(s_rt), .err_o(s_err),
        .err_cnt_o(s_cnt), .clear_err_i(in_clear[1])
    );

    floo_route_comp_arb #(
        .NUM_CHANNELS(1), .ROUTE_ALGO(1), .USE_ID_TABLE(1'b0), .ADDR_WIDTH(32),
        .ID_WIDTH(8), .XY_X_WIDTH(4), .XY_Y_WIDTH(4), .ROUTE_WIDTH(8),
        .XY_ADDR_OFFSET_X(12), .XY_ADDR_OFFSET_Y(16), .NUM_ADDR_RULES(1), .NUM_ROUTES(1),
        .ERR_CNT_WIDTH(16)
    ) u_xy (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(in_valid[2][0]), .ready_o(x_rdy),
        .addr_i(in_addr[2][0]), .id_i(in_id[2][0]), .addr_map_i(72'h0), .route_table_i(8'h00),
        .valid_o(x_v), .ready_i(in_ready[2][0]), .id_o(x_id), .route_o(x_rt), .err_o(x_err),
        .err_cnt_o(x_cnt), .clear_err_i(in_clear[2])
    );

    // Uniform view of the three DUTs for the per-cycle comparison.
    logic [1:0]      ov [3], ordy [3], oerr [3];
    logic [7:0]      oid [3][2], ort [3][2];
    logic [31:0]     ocnt [3];
    always_comb begin
        ov[0] = t_v;  ov[1] = s_v;  ov[2] = {1'b0, x_v};
        ordy[0] = t_rdy; ordy[1] = s_rdy; ordy[2] = {1'b0, x_rdy};
        oerr[0] = t_err; oerr[1] = s_err; oerr[2] = {1'b0, x_err};
        for (int c = 0; c < 2; c++) begin
            oid[0][c] = t_id[c]; ort[0][c] = t_rt[c];
            oid[1][c] = s_id[c]; ort[1][c] = s_rt[c];
        end
        oid[2][0] = x_id; ort[2][0] = x_rt; oid[2][1] = 8'h00; ort[2][1] = 8'h00;
        ocnt[0] = 32'(t_cnt); ocnt[1] = 32'(s_cnt); ocnt[2] = 32'(x_cnt);
    end

    // Reference model state
    int          vectors = 0;
    int          miscompares = 0;
    int          nch  [3] = '{2, 2, 1};
    int          cmax [3] = '{7, 65535, 65535};
    logic [31:0] rule_lo [3] = '{32'h0000, 32'h1000, 32'h1800};
    logic [31:0] rule_hi [3] = '{32'h1000, 32'h2000, 32'h2800};
    logic [7:0]  rule_id [3] = '{8'd3, 8'd5, 8'd7};
    logic [7:0]  m_rtab  [4] = '{8'h11, 8'h22, 8'hA5, 8'h44};
    int          m_ptr [3];
    logic [1:0]  m_v   [3];
    logic [7:0]  m_id  [3][2];
    logic [7:0]  m_rt  [3][2];
    logic        m_e   [3][2];
    int          m_cnt [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input int i, input logic [31:0] a, input logic [7:0] sid,
                                       output logic [7:0] id, output logic [7:0] rt, output logic e);
        id = 8'h00; rt = 8'h00; e = 1'b0;
        if (i == 0) begin
            e = 1'b1;
            for (int r = 0; r < 3; r++)
                if (e && a >= rule_lo[r] && a < rule_hi[r]) begin id = rule_id[r]; e = 1'b0; end
        end else if (i == 1) begin
            id = sid;
            if (sid < 8'd4) rt = m_rtab[int'(sid)];
            else e = 1'b1;
        end else begin
            id[3:0] = 4'((a >> 12) % 16);
            id[7:4] = 4'((a >> 16) % 16);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_ptr[i] = 0; m_v[i] = 2'b00; m_cnt[i] = 0;
            for (int c = 0; c < 2; c++) begin m_id[i][c] = 0; m_rt[i][c] = 0; m_e[i][c] = 0; end
        end
    endfunction

    // Compare at the falling edge, then advance the model to the next rising edge.
    task automatic tick();
        int g; logic [7:0] id, rt; logic e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            g = -1;
            for (int off = 0; off < nch[i]; off++) begin
                int c;
                c = (m_ptr[i] + off) % nch[i];
                if (g < 0 && in_valid[i][c] && (!m_v[i][c] || in_ready[i][c])) g = c;
            end
            chk($sformatf("i%0d ready_o", i), 32'(ordy[i]), (g < 0) ? 32'd0 : (32'd1 << g));
            chk($sformatf("i%0d valid_o", i), 32'(ov[i]), 32'(m_v[i]));
            chk($sformatf("i%0d err_cnt_o", i), ocnt[i], 32'(m_cnt[i]));
            for (int c = 0; c < nch[i]; c++) begin
                if (m_v[i][c]) begin
                    chk($sformatf("i%0d ch%0d id_o", i, c), 32'(oid[i][c]), 32'(m_id[i][c]));
                    chk($sformatf("i%0d ch%0d route_o", i, c), 32'(ort[i][c]), 32'(m_rt[i][c]));
                    chk($sformatf("i%0d ch%0d err_o", i, c), 32'(oerr[i][c]), 32'(m_e[i][c]));
                end
            end
            for (int c = 0; c < nch[i]; c++) begin
                if (c == g) begin
                    ref_decode(i, in_addr[i][c], in_id[i][c], id, rt, e);
                    m_v[i][c] = 1'b1; m_id[i][c] = id; m_rt[i][c] = rt; m_e[i][c] = e;
                end else if (in_ready[i][c]) begin
                    m_v[i][c] = 1'b0;
                end
            end
            if (in_clear[i]) m_cnt[i] = 0;
            if (g >= 0) begin
                if (m_e[i][g] && m_cnt[i] < cmax[i]) m_cnt[i]++;
                m_ptr[i] = (g + 1) % nch[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 2'b00; in_ready[i] = 2'b00; in_addr[i] = '0; in_id[i] = '0; in_clear[i] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("reset valid tab", 32'(t_v), 32'd0);
        chk("reset valid src", 32'(s_v), 32'd0);
        chk("reset valid xy", 32'(x_v), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset id tab", 32'(t_id), 32'd0);
        chk("reset route src", 32'(s_rt), 32'd0);
        chk("reset err_cnt tab", 32'(t_cnt), 32'd0);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        amap[0] = {8'd3, 32'h0000, 32'h1000};
        amap[1] = {8'd5, 32'h1000, 32'h2000};
        amap[2] = {8'd7, 32'h1800, 32'h2800};
        rtab    = {8'h44, 8'hA5, 8'h22, 8'h11};
        #2;
        do_reset();
        for (int i = 0; i < 3; i++) in_ready[i] = 2'b11;

        // Both channels streaming from a reset pointer alternate 0,1,0,1
        in_valid[0] = 2'b11;
        in_addr[0][0] = 32'h1000; in_addr[0][1] = 32'h0100;
        for (int k = 0; k < 6; k++) begin
            #1 chk("alternate grant", 32'(t_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end
        in_valid[0] = 2'b00;
        tick();

        // Single decode through the middle rule (also overlapped by rule 2)
        in_addr[0][0] = 32'h1800; in_valid[0] = 2'b01;
        tick();
        in_valid[0] = 2'b00;
        chk("plan valid ch0", 32'(t_v[0]), 32'd1);
        chk("plan id ch0", 32'(t_id[0]), 32'd5);
        chk("plan err ch0", 32'(t_err[0]), 32'd0);

        // Stalled ch0 keeps its result while ch1 is granted every cycle
        in_ready[0] = 2'b10; in_valid[0] = 2'b11; in_addr[0][0] = 32'h0500;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall grant ch1", 32'(t_rdy), 32'd2);
            tick();
            chk("stall id ch0", 32'(t_id[0]), 32'd5);
            chk("stall valid ch0", 32'(t_v[0]), 32'd1);
        end
        in_ready[0] = 2'b11;
        tick();
        in_valid[0] = 2'b00;
        tick();

        // Decode miss, then clear coinciding with a second miss, then clear alone
        in_addr[0][0] = 32'h3000; in_valid[0] = 2'b01;
        tick();
        in_valid[0] = 2'b00;
        chk("miss err", 32'(t_err[0]), 32'd1);
        chk("miss id", 32'(t_id[0]), 32'd0);
        chk("miss cnt", 32'(t_cnt), 32'd1);
        in_clear[0] = 1'b1; in_valid[0] = 2'b01;
        tick();
        in_valid[0] = 2'b00;
        chk("clear+miss cnt", 32'(t_cnt), 32'd1);
        tick();
        chk("clear cnt", 32'(t_cnt), 32'd0);
        in_clear[0] = 1'b0;

        // Saturation of the 3-bit counter
        in_valid[0] = 2'b01;
        for (int k = 0; k < 9; k++) tick();
        in_valid[0] = 2'b00;
        chk("saturated cnt", 32'(t_cnt), 32'd7);

        // Source routing lookup and out-of-range index
        in_id[1][0] = 8'd2; in_valid[1] = 2'b01;
        tick();
        chk("src route", 32'(s_rt[0]), 32'hA5);
        chk("src err", 32'(s_err[0]), 32'd0);
        in_id[1][0] = 8'd6;
        tick();
        in_valid[1] = 2'b00;
        chk("src oob route", 32'(s_rt[0]), 32'd0);
        chk("src oob err", 32'(s_err[0]), 32'd1);
        chk("src oob cnt", 32'(s_cnt), 32'd1);

        // XY coordinates, single-channel full throughput, then async reset mid-stream
        in_valid[2] = 2'b01; in_addr[2][0] = 32'h0003_5000;
        tick();
        chk("xy id", 32'(x_id), 32'h35);
        for (int k = 0; k < 4; k++) begin
            in_addr[2][0] = 32'(k) << 12;
            #1 chk("xy ready", 32'(x_rdy), 32'd1);
            tick();
            chk("xy stream id", 32'(x_id), 32'(k));
        end
        chk("xy valid before reset", 32'(x_v), 32'd1);
        do_reset();

        // Randomized traffic on all three configurations
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid[i] = 2'($urandom_range(0, 3));
                in_ready[i] = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
                for (int c = 0; c < 2; c++) begin
                    in_addr[i][c] = (i == 0) ? 32'($urandom_range(0, 32'h2FFF)) : 32'($urandom);
                    in_id[i][c]   = 8'($urandom_range(0, 7));
                end
                in_clear[i] = ($urandom_range(0, 63) == 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
